sdsg_calib_ctrl: RTL and testbench
==================================

Name: sdsg_calib_ctrl

Overview:
Calibration sequencer for a selectable-delay shift-register line with an 8-bit tap select, a 1-bit input and a 1-bit tapped output.
- On start, sweeps the tap select from 0 upward.
- At each tap, launches a single-cycle test pulse and times its echo.
- Locks onto the first tap whose measured pulse-to-echo latency matches a requested target.
- Sits between system control and the delay line, and owns the line's tap select and input during calibration.

Parameters:
DEPTH, 256, delay line length; taps 0..DEPTH-1
TAP_MAX, DEPTH-1, last tap tried in a sweep (must be ≤ DEPTH-1 and ≤ 255)
SETTLE_CYC, 256, cycles spent flushing the line before each pulse (≥ 1)
TIMEOUT, DEPTH+4, maximum echo wait in cycles (≤ 1023)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_ni  in  1  synchronous, active-low reset
start_i  in  1  begin calibration; sampled only in IDLE
abort_i  in  1  abandon calibration; return to IDLE
target_lat_i  in  8  required pulse-to-echo latency in cycles; latched on start
echo_i  in  1  tapped output of the delay line
delay_num_o  out  8  tap select driven to the delay line
pulse_o  out  1  input driven to the delay line
busy_o  out  1  calibration in progress
done_o  out  1  one-cycle pulse: lock achieved
fail_o  out  1  one-cycle pulse: sweep exhausted without a match
locked_o  out  1  result_o valid
result_o  out  8  locked tap

Behaviour:
- Reset (rst_ni=0 at an edge): state=IDLE; all outputs 0. Reset mid-sweep discards all progress.
- Internal registers:
  - tap: 8 bits.
  - lat: 10 bits, saturating.
  - tgt: 8 bits, latched target.
  - seen: 1 bit, echo captured.
- delay_num_o = tap in every state except IDLE. In IDLE, delay_num_o = result_o.
- pulse_o = 1 only in PULSE.
- busy_o = 1 in every state except IDLE.
- IDLE:
  - start_i=1 → tgt ← target_lat_i, tap ← 0, locked_o ← 0, go to SETTLE.
  - start_i while busy has no effect.
- SETTLE:
  - Runs exactly SETTLE_CYC cycles, then goes to PULSE.
  - echo_i is ignored.
- PULSE: one cycle; lat ← 0, seen ← 0; go to WAIT.
- WAIT, each cycle:
  - lat ← lat+1, so the first WAIT cycle observes lat=1.
  - If echo_i=1: capture that lat value, seen ← 1, go to EVAL.
  - If lat reaches TIMEOUT with no echo: seen ← 0, go to EVAL.
  - Echo timing: a line whose output is its first register (tap 0) echoes in the first WAIT cycle, so a tap-t line measures lat = t+1.
- EVAL, one cycle:
  - match = seen && (lat == tgt).
  - match → result_o ← tap, go to DONE.
  - else if tap == TAP_MAX → go to FAIL.
  - else tap ← tap+1, go to SETTLE.
  - tap never wraps.
- DONE: done_o=1 and locked_o ← 1 for one cycle; go to IDLE. result_o holds until the next lock or reset.
- FAIL:
  - fail_o=1 for one cycle; locked_o stays 0.
  - result_o is left unchanged from its previous value; locked_o=0 marks it invalid.
  - Go to IDLE.
- abort_i:
  - In any non-IDLE state, next state is IDLE; no done_o or fail_o is issued.
  - locked_o stays 0, because starting calibration cleared it.
  - Priority: abort_i > EVAL decision.
- Target 0 can never match; the sweep runs to FAIL.
- Multiple echo cycles: only the first is used; later ones are ignored until the next PULSE.

Optional Feature:
SDSG_CAL_TOL_EN
- Defined:
  - Adds port tol_i (in, 4 bits), latched with target on start.
  - match = seen && |lat − tgt| ≤ tol. The comparison is evaluated at 10-bit width with no wrap.
  - The first matching tap in sweep order wins.
- Undefined: tol_i is absent and the exact-match rule applies.

Test Plan:
- Bench setup: the bench instantiates a DEPTH=256 delay line driven by pulse_o and delay_num_o, with its output wired to echo_i. SETTLE_CYC=256.
1. Reset, then start_i at cycle 0 with target 1:
   - SETTLE occupies cycles 1–256 and pulse_o=1 at cycle 257.
   - echo_i=1 at cycle 258.
   - done_o=1 at cycle 260 with result_o=0 and locked_o=1.
   - delay_num_o=0 after return to IDLE.
2. Target 5 → taps 0..3 are rejected; done_o fires with result_o=4 and locked_o=1; no fail_o.
3. Target 0 → all 256 taps are swept; fail_o pulses once; locked_o=0; busy_o falls in the same cycle fail_o clears.
4. echo_i tied to 0 with target 10 → every tap times out after TIMEOUT=260 wait cycles; fail_o pulses after tap 255; result_o keeps its earlier lock value.
5. Lock on target 5, then restart with target 40, then assert abort_i while tap=20:
   - Restart: locked_o drops to 0 on the start edge.
   - Abort: IDLE on the next cycle; no done_o or fail_o; locked_o=0; delay_num_o returns to 4.
   - start_i pulsed during SETTLE is ignored.
6. rst_ni=0 during WAIT → all outputs are 0 on the next cycle. With SDSG_CAL_TOL_EN, tol=2 and target 7 → result_o=4 (lat 5 is within ±2).

Source files
------------

// File: rtl/sdsg_calib_ctrl_if.sv
// sdsg_calib_ctrl_if: control, status and delay-line signals of the calibration sequencer.
// tol_i exists only when SDSG_CAL_TOL_EN is defined.
interface sdsg_calib_ctrl_if;
    logic       start_i;
    logic       abort_i;
    logic [7:0] target_lat_i;
`ifdef SDSG_CAL_TOL_EN
    logic [3:0] tol_i;
`endif
    logic       echo_i;
    logic [7:0] delay_num_o;
    logic       pulse_o;
    logic       busy_o;
    logic       done_o;
    logic       fail_o;
    logic       locked_o;
    logic [7:0] result_o;

    modport master (
        input  delay_num_o, pulse_o, busy_o, done_o, fail_o, locked_o, result_o,
        output start_i, abort_i, target_lat_i, echo_i
`ifdef SDSG_CAL_TOL_EN
        , output tol_i
`endif
    );

    modport slave (
        input  start_i, abort_i, target_lat_i, echo_i,
`ifdef SDSG_CAL_TOL_EN
        input  tol_i,
`endif
        output delay_num_o, pulse_o, busy_o, done_o, fail_o, locked_o, result_o
    );
endinterface

// File: rtl/sdsg_calib_ctrl.sv
// sdsg_calib_ctrl: sweeps delay-line taps, times a test pulse echo and locks on the first tap matching the target.
// Define SDSG_CAL_TOL_EN to add tol_i and accept |lat - tgt| <= tol instead of an exact match.
module sdsg_calib_ctrl #(
    parameter int DEPTH      = 256,
    parameter int TAP_MAX    = DEPTH - 1,
    parameter int SETTLE_CYC = 256,
    parameter int TIMEOUT    = DEPTH + 4
) (
    input logic clk_i,
    input logic rst_ni,
    sdsg_calib_ctrl_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, PULSE, WAIT, EVAL, DONE, FAIL} state_t;

    state_t        state;
    logic [7:0]    tap, tgt, result;
    logic [9:0]    lat, lat_inc;
    logic [SW-1:0] cnt;
    logic          seen, done, fail, locked, match;

    assign lat_inc = &lat ? lat : lat + 10'd1;

`ifdef SDSG_CAL_TOL_EN
    logic [3:0] tol;
    logic [9:0] diff;
    assign diff  = lat >= {2'b0, tgt} ? lat - {2'b0, tgt} : {2'b0, tgt} - lat;
    assign match = seen && diff <= {6'b0, tol};
`else
    assign match = seen && lat == {2'b0, tgt};
`endif

    assign bus.delay_num_o = state == IDLE ? result : tap;
    assign bus.pulse_o     = state == PULSE;
    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = done;
    assign bus.fail_o      = fail;
    assign bus.locked_o    = locked;
    assign bus.result_o    = result;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            tap    <= '0;
            tgt    <= '0;
            lat    <= '0;
            cnt    <= '0;
            seen   <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            fail   <= 1'b0;
            locked <= 1'b0;
`ifdef SDSG_CAL_TOL_EN
            tol    <= '0;
`endif
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            // abort wins over every state decision, including the EVAL verdict
            if (state != IDLE && bus.abort_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.start_i) begin
                        tgt    <= bus.target_lat_i;
`ifdef SDSG_CAL_TOL_EN
                        tol    <= bus.tol_i;
`endif
                        tap    <= '0;
                        cnt    <= '0;
                        locked <= 1'b0;
                        state  <= SETTLE;
                    end
                    SETTLE: if (cnt == SW'(SETTLE_CYC - 1)) state <= PULSE;
                            else cnt <= cnt + 1'b1;
                    PULSE: begin
                        lat   <= '0;
                        seen  <= 1'b0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        lat <= lat_inc;
                        if (bus.echo_i) begin
                            seen  <= 1'b1;
                            state <= EVAL;
                        end else if (lat_inc == 10'(TIMEOUT)) begin
                            seen  <= 1'b0;
                            state <= EVAL;
                        end
                    end
                    EVAL: if (match) begin
                        result <= tap;
                        done   <= 1'b1;
                        locked <= 1'b1;
                        state  <= DONE;
                    end else if (tap == 8'(TAP_MAX)) begin
                        fail  <= 1'b1;
                        state <= FAIL;
                    end else begin
                        tap   <= tap + 8'd1;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdsg_calib_ctrl.sv
// tb_sdsg_calib_ctrl: drives the calibration sequencer against behavioural delay lines and a sweep model.
// Build with SDSG_CAL_TOL_EN defined to also exercise the tolerance match.
module tb_sdsg_calib_ctrl;
    localparam int ST  = 16;
    localparam int TO  = 260;
    localparam int TM2 = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic echo_en_t = 1'b1;
    logic [255:0] line_m = '0;
    logic [255:0] line_t = '0;
    int vec = 0;
    int errs = 0;
    int tol_v = 0;
    int last_res = 0;

    sdsg_calib_ctrl_if m ();
    sdsg_calib_ctrl_if t ();

    sdsg_calib_ctrl #(.DEPTH(256), .SETTLE_CYC(ST)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(m));
    sdsg_calib_ctrl #(.DEPTH(256), .TAP_MAX(TM2), .SETTLE_CYC(ST)) u_to (.clk_i(clk), .rst_ni(rst_n), .bus(t));

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        line_m <= {line_m[254:0], m.pulse_o};
        line_t <= {line_t[254:0], t.pulse_o};
    end
    assign m.echo_i = line_m[m.delay_num_o];
    assign t.echo_i = echo_en_t & line_t[t.delay_num_o];

    // Returns the locking tap (or -1) and the cycle, counted from the start edge, where done/fail shows.
    function automatic int model(input int tgt, input int tol, input int tmax, input bit echo_on, output int cyc);
        int w;
        cyc = 1;
        for (int j = 0; j <= tmax; j++) begin
            w = echo_on ? j + 1 : TO;
            cyc += ST + 2 + w;
            if (echo_on && (w > tgt ? w - tgt : tgt - w) <= tol) return j;
        end
        return -1;
    endfunction

    task automatic run_m(input int tgt, output int k, output bit d, output bit f);
        m.target_lat_i = 8'(tgt);
`ifdef SDSG_CAL_TOL_EN
        m.tol_i = 4'(tol_v);
`endif
        m.start_i = 1'b1;
        k = 0; d = 1'b0; f = 1'b0;
        while (!d && !f && k < 60000) begin
            @(posedge clk); #1;
            m.start_i = 1'b0;
            k++;
            d = m.done_o;
            f = m.fail_o;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (m.busy_o !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", m.busy_o); end
        vec++; if (m.pulse_o !== 1'b0) begin errs++; $display("FAIL reset pulse: got %b want 0", m.pulse_o); end
        vec++; if (m.done_o !== 1'b0 || m.fail_o !== 1'b0) begin errs++; $display("FAIL reset done/fail: got %b%b want 00", m.done_o, m.fail_o); end
        vec++; if (m.locked_o !== 1'b0) begin errs++; $display("FAIL reset locked: got %b want 0", m.locked_o); end
        vec++; if (m.result_o !== 8'd0 || m.delay_num_o !== 8'd0) begin errs++; $display("FAIL reset result/delay: got %0d/%0d want 0/0", m.result_o, m.delay_num_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_tap;
        int pk = 0, ek = 0, dk = 0;
        logic [7:0] res = 'x;
        logic lk = 1'bx;
        m.target_lat_i = 8'd1;
        m.start_i = 1'b1;
        for (int k = 1; k <= 200 && dk == 0; k++) begin
            @(posedge clk); #1;
            m.start_i = 1'b0;
            if (m.pulse_o && pk == 0) pk = k;
            if (m.echo_i && ek == 0) ek = k;
            if (m.done_o) begin dk = k; res = m.result_o; lk = m.locked_o; end
        end
        vec++; if (pk != ST + 1) begin errs++; $display("FAIL first pulse cycle: got %0d want %0d", pk, ST + 1); end
        vec++; if (ek != ST + 2) begin errs++; $display("FAIL first echo cycle: got %0d want %0d", ek, ST + 2); end
        vec++; if (dk != ST + 4) begin errs++; $display("FAIL first done cycle: got %0d want %0d", dk, ST + 4); end
        vec++; if (res !== 8'd0 || lk !== 1'b1) begin errs++; $display("FAIL first result/locked: got %0d/%b want 0/1", res, lk); end
        @(posedge clk); #1;
        vec++; if (m.delay_num_o !== 8'd0 || m.busy_o !== 1'b0 || m.done_o !== 1'b0) begin
            errs++; $display("FAIL first idle: got delay=%0d busy=%b done=%b want 0/0/0", m.delay_num_o, m.busy_o, m.done_o);
        end
    endtask

    task automatic test_sweep;
        int tg, ex, ec, k;
        bit d, f;
        for (int i = 0; i < 7; i++) begin
            tg = i == 0 ? 5 : int'($urandom_range(2, 32));
`ifdef SDSG_CAL_TOL_EN
            tol_v = i == 0 ? 0 : int'($urandom_range(0, 3));
`else
            tol_v = 0;
`endif
            ex = model(tg, tol_v, 255, 1'b1, ec);
            run_m(tg, k, d, f);
            vec++; if ({d, f} !== 2'b10) begin errs++; $display("FAIL sweep t=%0d done/fail: got %b%b want 10", tg, d, f); end
            vec++; if (k != ec) begin errs++; $display("FAIL sweep t=%0d cycle: got %0d want %0d", tg, k, ec); end
            vec++; if (m.result_o !== 8'(ex) || m.locked_o !== 1'b1) begin
                errs++; $display("FAIL sweep t=%0d result/locked: got %0d/%b want %0d/1", tg, m.result_o, m.locked_o, ex);
            end
            @(posedge clk); #1;
            vec++; if (m.busy_o !== 1'b0 || m.delay_num_o !== 8'(ex)) begin
                errs++; $display("FAIL sweep t=%0d idle: got busy=%b delay=%0d want 0/%0d", tg, m.busy_o, m.delay_num_o, ex);
            end
            last_res = ex;
        end
        tol_v = 0;
    endtask

    task automatic test_target0;
        int ec, k;
        bit d, f;
        void'(model(0, 0, 255, 1'b1, ec));
        run_m(0, k, d, f);
        vec++; if ({d, f} !== 2'b01) begin errs++; $display("FAIL target0 done/fail: got %b%b want 01", d, f); end
        vec++; if (k != ec) begin errs++; $display("FAIL target0 cycle: got %0d want %0d", k, ec); end
        vec++; if (m.locked_o !== 1'b0 || m.result_o !== 8'(last_res) || m.busy_o !== 1'b1) begin
            errs++; $display("FAIL target0 status: got locked=%b result=%0d busy=%b want 0/%0d/1", m.locked_o, m.result_o, m.busy_o, last_res);
        end
        @(posedge clk); #1;
        vec++; if (m.fail_o !== 1'b0 || m.busy_o !== 1'b0) begin
            errs++; $display("FAIL target0 end: got fail=%b busy=%b want 0/0", m.fail_o, m.busy_o);
        end
    endtask

    task automatic test_timeout;
        int ex, ec, k;
        ex = model(3, 0, TM2, 1'b1, ec);
        t.target_lat_i = 8'd3;
        t.start_i = 1'b1;
        k = 0;
        while (!t.done_o && !t.fail_o && k < 2000) begin @(posedge clk); #1; t.start_i = 1'b0; k++; end
        vec++; if (t.done_o !== 1'b1 || t.result_o !== 8'(ex) || k != ec) begin
            errs++; $display("FAIL timeout prelock: got done=%b result=%0d cyc=%0d want 1/%0d/%0d", t.done_o, t.result_o, k, ex, ec);
        end
        @(posedge clk); #1;
        void'(model(10, 0, TM2, 1'b0, ec));
        echo_en_t = 1'b0;
        t.target_lat_i = 8'd10;
        t.start_i = 1'b1;
        k = 0;
        while (!t.done_o && !t.fail_o && k < 10000) begin @(posedge clk); #1; t.start_i = 1'b0; k++; end
        vec++; if (t.fail_o !== 1'b1 || k != ec) begin errs++; $display("FAIL timeout fail: got fail=%b cyc=%0d want 1/%0d", t.fail_o, k, ec); end
        vec++; if (t.result_o !== 8'(ex) || t.locked_o !== 1'b0) begin
            errs++; $display("FAIL timeout result: got %0d/%b want %0d/0", t.result_o, t.locked_o, ex);
        end
        @(posedge clk); #1;
        echo_en_t = 1'b1;
    endtask

    task automatic test_abort;
        int k;
        bit d, f, seen_df = 1'b0, ign_ok = 1'b0, hit = 1'b0;
        run_m(5, k, d, f);
        @(posedge clk); #1;
        m.target_lat_i = 8'd40;
        m.start_i = 1'b1;
        @(posedge clk); #1;
        m.start_i = 1'b0;
        vec++; if (m.locked_o !== 1'b0 || m.busy_o !== 1'b1) begin
            errs++; $display("FAIL abort restart: got locked=%b busy=%b want 0/1", m.locked_o, m.busy_o);
        end
        for (int c = 0; c < 5000 && !hit; c++) begin
            if (m.delay_num_o == 8'd10 && !ign_ok && m.busy_o) begin
                m.target_lat_i = 8'd3;
                m.start_i = 1'b1;
                @(posedge clk); #1;
                m.start_i = 1'b0;
                ign_ok = 1'b1;
                vec++; if (m.delay_num_o !== 8'd10) begin errs++; $display("FAIL abort ignored start: got tap %0d want 10", m.delay_num_o); end
            end
            if (m.delay_num_o == 8'd20 && m.busy_o) begin
                hit = 1'b1;
                m.abort_i = 1'b1;
            end
            @(posedge clk); #1;
            m.abort_i = 1'b0;
            seen_df |= m.done_o | m.fail_o;
        end
        vec++; if (!hit || m.busy_o !== 1'b0 || m.delay_num_o !== 8'd4) begin
            errs++; $display("FAIL abort idle: got reached=%b busy=%b delay=%0d want 1/0/4", hit, m.busy_o, m.delay_num_o);
        end
        vec++; if (seen_df || m.locked_o !== 1'b0) begin
            errs++; $display("FAIL abort flags: got done_or_fail=%b locked=%b want 0/0", seen_df, m.locked_o);
        end
    endtask

    task automatic test_reset_mid;
        bit in_wait = 1'b0;
        m.target_lat_i = 8'd50;
        m.start_i = 1'b1;
        for (int c = 0; c < 1000 && !in_wait; c++) begin
            @(posedge clk); #1;
            m.start_i = 1'b0;
            in_wait = m.pulse_o;
        end
        @(posedge clk); #1;
        vec++; if (!in_wait || m.busy_o !== 1'b1) begin errs++; $display("FAIL midreset pre: got wait=%b busy=%b want 1/1", in_wait, m.busy_o); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        vec++; if ({m.busy_o, m.pulse_o, m.done_o, m.fail_o, m.locked_o} !== 5'b0 || m.result_o !== 8'd0 || m.delay_num_o !== 8'd0) begin
            errs++; $display("FAIL midreset outputs: got flags=%b%b%b%b%b result=%0d delay=%0d want 0", m.busy_o, m.pulse_o, m.done_o, m.fail_o, m.locked_o, m.result_o, m.delay_num_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef SDSG_CAL_TOL_EN
    task automatic test_tol;
        int k;
        bit d, f;
        tol_v = 2;
        run_m(7, k, d, f);
        vec++; if (!d || m.result_o !== 8'd4) begin errs++; $display("FAIL tol lock: got done=%b result=%0d want 1/4", d, m.result_o); end
        @(posedge clk); #1;
        tol_v = 0;
    endtask
`endif

    initial begin
        m.start_i = 1'b0; m.abort_i = 1'b0; m.target_lat_i = '0;
        t.start_i = 1'b0; t.abort_i = 1'b0; t.target_lat_i = '0;
`ifdef SDSG_CAL_TOL_EN
        m.tol_i = '0; t.tol_i = '0;
`endif
        test_reset;
        test_first_tap;
        test_sweep;
        test_target0;
        test_timeout;
        test_abort;
        test_reset_mid;
`ifdef SDSG_CAL_TOL_EN
        test_tol;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
